// File: rtl/truth_table_scanner_pkg.sv
// ---------------------------------------------------------------------------
// truth_table_pkg
// Shared definitions for the truth-table scanner:
//   N_DEFAULT     - default number of inputs of the function under scan
//   state_e       - scanner FSM state encoding
//   pattern_count - number of input patterns (2^n) for an n-input function
// Optional feature macro: SETTLE_EN adds the SETTLE state to state_e.
// ---------------------------------------------------------------------------
package truth_table_pkg;

    localparam int N_DEFAULT = 2;

`ifdef SETTLE_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        SETTLE = 2'd2,
        DONE   = 2'd3
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DONE   = 2'd3
    } state_e;
`endif

    function automatic int pattern_count(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// ---------------------------------------------------------------------------
// truth_table_scanner_if
// Bundles the scanner's request/response signals.
//   start_i    - request a full scan (scanner samples it only in IDLE)
//   s_i        - output of the function under scan
//   expected_i - reference table, bit i = expected s for pattern i
//   x_o        - registered input pattern driven to the function
//   table_o    - captured table, bit i = s sampled while x == i
//   busy_o     - scan in progress
//   done_o     - one-cycle completion pulse
//   match_o    - table_o == expected_i, valid from done until next start
// Modports: master (environment side), slave (scanner side).
// ---------------------------------------------------------------------------
interface truth_table_scanner_if
    import truth_table_pkg::*;
#(
    parameter int N = N_DEFAULT
);
    localparam int P = 1 << N;

    logic         start_i;
    logic         s_i;
    logic [P-1:0] expected_i;
    logic [N-1:0] x_o;
    logic [P-1:0] table_o;
    logic         busy_o;
    logic         done_o;
    logic         match_o;

    modport master (
        output start_i, s_i, expected_i,
        input  x_o, table_o, busy_o, done_o, match_o
    );

    modport slave (
        input  start_i, s_i, expected_i,
        output x_o, table_o, busy_o, done_o, match_o
    );

endinterface

// File: rtl/truth_table_scanner_pattern_counter.sv
// ---------------------------------------------------------------------------
// pattern_counter
// N+1-bit pattern index generator for the scanner. The extra MSB keeps the
// index from wrapping silently; the low N bits form the pattern x.
//   clk, reset - clock, asynchronous active-high reset
//   clear_i    - synchronous clear to 0 (has priority over enable_i)
//   enable_i   - advance to the next pattern
//   count_o    - current index (N+1 bits)
//   last_o     - index is the final pattern 2^N-1
// ---------------------------------------------------------------------------
module pattern_counter
    import truth_table_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       enable_i,
    output logic [N:0] count_o,
    output logic       last_o
);
    localparam logic [N:0] LAST = {1'b0, {N{1'b1}}};
    localparam logic [N:0] ONE  = {{N{1'b0}}, 1'b1};

    logic [N:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign last_o  = (count_q == LAST);

endmodule

// File: rtl/truth_table_scanner.sv
// ---------------------------------------------------------------------------
// truth_table_scanner
// Characterises an N-input combinational function: steps x through every
// pattern 0..2^N-1, captures s for each into a table and compares the table
// against a reference.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - truth_table_scanner_if.slave (start/s/expected in,
//           x/table/busy/done/match out)
// Optional feature macro: SETTLE_EN inserts one SETTLE cycle per pattern so
// the function output can settle before it is sampled.
// ---------------------------------------------------------------------------
module truth_table_scanner
    import truth_table_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset,
    truth_table_scanner_if.slave        bus
);
    localparam int P = pattern_count(N);

    state_e       state_q, state_d;
    logic [N:0]   idx;
    logic         last;
    logic         clear;
    logic         sample;
    logic         advance;
    logic         busy;
    logic         done;
    logic [P-1:0] table_q, table_d;
    logic         match_q, match_d;

    pattern_counter #(.N(N)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (clear),
        .enable_i (advance),
        .count_o  (idx),
        .last_o   (last)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE, so requests during
    // a scan are dropped rather than queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
`ifdef SETTLE_EN
            IDLE:    if (bus.start_i) state_d = SETTLE;
            SETTLE:  state_d = RUN;
            RUN:     state_d = last ? DONE : SETTLE;
`else
            IDLE:    if (bus.start_i) state_d = RUN;
            RUN:     state_d = last ? DONE : RUN;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode. The index MSB guard keeps a corrupted index
    // from ever writing outside the table.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        clear   = 1'b0;
        sample  = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE:    clear = bus.start_i;
`ifdef SETTLE_EN
            SETTLE:  busy = 1'b1;
`endif
            RUN: begin
                busy    = 1'b1;
                sample  = ~idx[N];
                advance = ~idx[N] & ~last;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Table capture; the match is judged on the table including the final
    // sample, so it is evaluated on the next-state value.
    always_comb begin
        table_d = table_q;
        match_d = match_q;
        if (clear) begin
            table_d = '0;
            match_d = 1'b0;
        end else if (sample) begin
            table_d[idx[N-1:0]] = bus.s_i;
            if (last) begin
                match_d = (table_d == bus.expected_i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            table_q <= '0;
            match_q <= 1'b0;
        end else begin
            table_q <= table_d;
            match_q <= match_d;
        end
    end

    assign bus.x_o     = idx[N-1:0];
    assign bus.table_o = table_q;
    assign bus.busy_o  = busy;
    assign bus.done_o  = done;
    assign bus.match_o = match_q;

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 Parameter: N, default 2, number of inputs of the combinational function under characterisation (1..4).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request a full scan; sampled only in IDLE.
REQ-005 Port: s  input  1  output of the function under scan.
REQ-006 Port: expected  input  2^N  reference table; bit i is the expected s for input pattern i.
REQ-007 Port: x  output  N  registered input pattern driven to the function; bit N-1 = first operand (x), bit 0 = last operand (y).
REQ-008 Port: table  output  2^N  captured table; bit i is s sampled while x == i.
REQ-009 Port: busy  output  1  high in RUN and SETTLE states.
REQ-010 Port: done  output  1  one-cycle pulse when the scan completes.
REQ-011 Port: match  output  1  high when table == expected; valid from done, held until the next accepted start.

Function
REQ-012 The block SHALL implement FSM states IDLE, RUN, SETTLE (present only with SETTLE_EN) and DONE.
REQ-013 IDLE, start=1 at an edge: idx<=0, x<=0, table<=0, match<=0, next state RUN (SETTLE when SETTLE_EN is defined).
REQ-014 IDLE, start=0: all outputs hold their values.
REQ-015 RUN, every edge: table[idx]<=s.
REQ-016 RUN, idx==2^N-1: next state DONE and match<=({s,table[2^N-2:0]}==expected).
REQ-017 RUN, idx<2^N-1: idx<=idx+1, x<=idx+1, next state RUN (SETTLE with SETTLE_EN).
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-019 start SHALL be ignored in RUN, SETTLE and DONE; there is no queuing.
REQ-020 Latency without SETTLE_EN: start accepted at edge 0, samples at edges 1..2^N, done high in the cycle after edge 2^N.
REQ-021 Counter arithmetic SHALL be N+1 bits wide so that idx never wraps silently; x is its low N bits.
REQ-022 x SHALL stay at 2^N-1 after a scan until the next accepted start.

Reset
REQ-023 Asserting reset at any time, including mid-scan, SHALL force state IDLE, x=0, idx=0, table=0, busy=0, done=0, match=0 immediately.
REQ-024 After reset deasserts, the first start SHALL begin a fresh scan from pattern 0.

Configuration
REQ-025 Macro SETTLE_EN defined: each pattern gets one SETTLE cycle (hold x, no sample) before RUN samples s; done is high in the cycle after edge 2*2^N.
REQ-026 Macro SETTLE_EN undefined: the SETTLE state and its logic SHALL be absent, and the timing of REQ-020 applies.

Structure
REQ-027 Package truth_table_pkg SHALL hold the state enumeration typedef and the default N constant.
REQ-028 Sub-module pattern_counter (clear, enable, N+1-bit count, last flag) SHALL generate idx and x.

Verification
REQ-029 N=2, function s=~(x&~y)|(x|y), expected=4'b1111, pulse start -> x steps 00,01,10,11; table=4'b1111; match=1; done one cycle after edge 4.
REQ-030 N=2, s=x&y, expected=4'b1000 -> table=4'b1000, match=1; rerun with expected=4'b1001 -> match=0.
REQ-031 N=2, s=x^y, start held high for 10 cycles -> exactly one scan per IDLE visit; busy=1 during RUN; table=4'b0110.
REQ-032 Reset asserted while idx=2 -> next cycle shows x=0, table=0, busy=0, done=0; new start gives a full correct scan.
REQ-033 SETTLE_EN defined, s=x|y -> each x value held for 2 cycles; done after edge 8; table=4'b1110.
REQ-034 N=3, s=majority(x2,x1,x0) -> table=8'b11101000, done after edge 8.
